// File: rtl/usb_txn_scheduler.sv
// USB transaction scheduler: round-robin write/read arbitration and packet
// sequencing (token, data, handshake, retries) toward the bitstream encoder.
module usb_txn_scheduler #(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        wr_req,
    input  logic [6:0]  wr_addr,
    input  logic [3:0]  wr_endp,
    input  logic [63:0] wr_data,
    output logic        wr_gnt,
    output logic        wr_done,
    output logic        wr_err,
    input  logic        rd_req,
    input  logic [6:0]  rd_addr,
    input  logic [3:0]  rd_endp,
    output logic        rd_gnt,
    output logic        rd_done,
    output logic        rd_err,
    output logic [63:0] rd_data,
    output logic        pktready,
    output logic [3:0]  pid,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [63:0] data,
    input  logic        gotpkt,
    input  logic        sending,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_data,
    output logic        busy
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [3:0] {
        S_IDLE, S_TOKEN, S_TOKEN_WAIT, S_DATA, S_DATA_WAIT, S_WAIT_HS,
        S_WAIT_RX, S_SEND_ACK, S_ACK_WAIT, S_RETRY, S_DONE
    } state_t;

    state_t        state_q;
    logic          is_rd_q, last_rd_q, seen_q;
    logic [6:0]    cap_addr_q;
    logic [3:0]    cap_endp_q;
    logic [63:0]   cap_data_q, rx_buf_q;
    logic [TW-1:0] timer_q;
    logic [RW-1:0] retry_q;
    logic          wr_done_q, wr_err_q, rd_done_q, rd_err_q, busy_q, pktready_q;
    logic [63:0]   rd_data_q, data_q;
    logic [3:0]    pid_q, endp_q;
    logic [6:0]    addr_q;
    logic          pick_wr_s, pick_rd_s, timeout_s;

    // On contention the requester that did not win last time is picked.
    assign pick_wr_s = wr_req & (~rd_req | last_rd_q);
    assign pick_rd_s = rd_req & (~wr_req | ~last_rd_q);
    assign wr_gnt    = rst_L & (state_q == S_IDLE) & pick_wr_s;
    assign rd_gnt    = rst_L & (state_q == S_IDLE) & pick_rd_s;
    assign timeout_s = (timer_q == TW'(TIMEOUT));

    assign wr_done  = wr_done_q;
    assign wr_err   = wr_err_q;
    assign rd_done  = rd_done_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = rd_data_q;
    assign pktready = pktready_q;
    assign pid      = pid_q;
    assign addr     = addr_q;
    assign endp     = endp_q;
    assign data     = data_q;
    assign busy     = busy_q;

    // Transaction sequencer with registered encoder fields and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q    <= S_IDLE;
            is_rd_q    <= 1'b0;
            last_rd_q  <= 1'b1;
            seen_q     <= 1'b0;
            cap_addr_q <= 7'd0;
            cap_endp_q <= 4'd0;
            cap_data_q <= 64'd0;
            rx_buf_q   <= 64'd0;
            timer_q    <= '0;
            retry_q    <= '0;
            wr_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= 64'd0;
            busy_q     <= 1'b0;
            pktready_q <= 1'b0;
            pid_q      <= 4'd0;
            addr_q     <= 7'd0;
            endp_q     <= 4'd0;
            data_q     <= 64'd0;
        end else begin
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_wr_s || pick_rd_s) begin
                        is_rd_q    <= pick_rd_s;
                        last_rd_q  <= pick_rd_s;
                        cap_addr_q <= pick_rd_s ? rd_addr : wr_addr;
                        cap_endp_q <= pick_rd_s ? rd_endp : wr_endp;
                        cap_data_q <= wr_data;
                        retry_q    <= '0;
                        pktready_q <= 1'b1;
                        pid_q      <= pick_rd_s ? PID_IN : PID_OUT;
                        addr_q     <= pick_rd_s ? rd_addr : wr_addr;
                        endp_q     <= pick_rd_s ? rd_endp : wr_endp;
                        busy_q     <= 1'b1;
                        state_q    <= S_TOKEN;
                    end
                end
                S_TOKEN, S_DATA, S_SEND_ACK: begin
                    if (gotpkt) begin
                        pktready_q <= 1'b0;
                        seen_q     <= 1'b0;
                        state_q    <= (state_q == S_TOKEN) ? S_TOKEN_WAIT :
                                      (state_q == S_DATA)  ? S_DATA_WAIT  : S_ACK_WAIT;
                    end
                end
                S_TOKEN_WAIT, S_DATA_WAIT, S_ACK_WAIT: begin
                    if (sending) begin
                        seen_q <= 1'b1;
                    end else if (seen_q) begin
                        timer_q <= '0;
                        if (state_q == S_ACK_WAIT) begin
                            rd_done_q <= 1'b1;
                            rd_data_q <= rx_buf_q;
                            state_q   <= S_DONE;
                        end else if (state_q == S_DATA_WAIT) begin
                            state_q <= S_WAIT_HS;
                        end else if (is_rd_q) begin
                            state_q <= S_WAIT_RX;
                        end else begin
                            pktready_q <= 1'b1;
                            pid_q      <= PID_DATA0;
                            data_q     <= cap_data_q;
                            state_q    <= S_DATA;
                        end
                    end
                end
                S_WAIT_HS, S_WAIT_RX: begin
                    // A valid packet in the same cycle as the timeout takes priority.
                    if (rx_valid && state_q == S_WAIT_HS && rx_pid == PID_ACK) begin
                        wr_done_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (rx_valid && state_q == S_WAIT_RX && rx_pid == PID_DATA0) begin
                        rx_buf_q   <= rx_data;
                        pktready_q <= 1'b1;
                        pid_q      <= PID_ACK;
                        addr_q     <= 7'd0;
                        endp_q     <= 4'd0;
                        data_q     <= 64'd0;
                        state_q    <= S_SEND_ACK;
                    end else if ((rx_valid && rx_pid == PID_NAK) || timeout_s) begin
                        state_q <= S_RETRY;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_RETRY: begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_q    <= retry_q + RW'(1);
                        pktready_q <= 1'b1;
                        pid_q      <= is_rd_q ? PID_IN : PID_OUT;
                        addr_q     <= cap_addr_q;
                        endp_q     <= cap_endp_q;
                        state_q    <= S_TOKEN;
                    end else begin
                        wr_done_q <= ~is_rd_q;
                        wr_err_q  <= ~is_rd_q;
                        rd_done_q <= is_rd_q;
                        rd_err_q  <= is_rd_q;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    pktready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_txn_scheduler.sv
// Directed, table-driven bench for usb_txn_scheduler with a small encoder /
// receiver model that acknowledges packets and optionally answers them.
module tb_usb_txn_scheduler;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    logic        clk = 1'b0;
    logic        rst_L;
    logic        wr_req, rd_req;
    logic [6:0]  wr_addr, rd_addr;
    logic [3:0]  wr_endp, rd_endp;
    logic [63:0] wr_data;
    logic        wr_gnt, wr_done, wr_err, rd_gnt, rd_done, rd_err;
    logic [63:0] rd_data;
    logic        pktready;
    logic [3:0]  pid, endp;
    logic [6:0]  addr;
    logic [63:0] data;
    logic        gotpkt, sending, rx_valid;
    logic [3:0]  rx_pid;
    logic [63:0] rx_data;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          tok_cnt [16];
    int          ack_bad;
    logic [6:0]  last_tok_addr;
    logic [3:0]  last_tok_endp;
    logic [63:0] last_d0_data;
    logic [3:0]  resp_wr_pid, resp_rd_pid;
    logic [63:0] resp_data;

    typedef struct {
        logic        is_rd;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] wdata;
        logic [3:0]  resp;
        logic [63:0] rx_data;
        logic        exp_err;
        int          exp_tok;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [7];

    usb_txn_scheduler dut (
        .clk(clk), .rst_L(rst_L),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_endp(wr_endp), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .wr_done(wr_done), .wr_err(wr_err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_endp(rd_endp),
        .rd_gnt(rd_gnt), .rd_done(rd_done), .rd_err(rd_err), .rd_data(rd_data),
        .pktready(pktready), .pid(pid), .addr(addr), .endp(endp), .data(data),
        .gotpkt(gotpkt), .sending(sending), .rx_valid(rx_valid),
        .rx_pid(rx_pid), .rx_data(rx_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Encoder/receiver model: takes every offered packet, shifts it for three
    // cycles, then answers DATA0 or IN packets when a response is armed.
    initial begin : encoder_model
        logic [3:0] p;
        gotpkt = 1'b0; sending = 1'b0; rx_valid = 1'b0; rx_pid = 4'd0; rx_data = 64'd0;
        for (int i = 0; i < 16; i++) tok_cnt[i] = 0;
        ack_bad = 0;
        last_tok_addr = 7'd0; last_tok_endp = 4'd0; last_d0_data = 64'd0;
        forever begin
            @(negedge clk);
            if (pktready === 1'b1) begin
                p = pid;
                tok_cnt[p] = tok_cnt[p] + 1;
                if (p == PID_OUT || p == PID_IN) begin
                    last_tok_addr = addr;
                    last_tok_endp = endp;
                end
                if (p == PID_DATA0) last_d0_data = data;
                if (p == PID_ACK && (addr != 7'd0 || endp != 4'd0 || data != 64'd0)) ack_bad++;
                gotpkt = 1'b1;
                @(negedge clk);
                gotpkt = 1'b0;
                sending = 1'b1;
                repeat (3) @(negedge clk);
                sending = 1'b0;
                if ((p == PID_DATA0 && resp_wr_pid != 4'd0) || (p == PID_IN && resp_rd_pid != 4'd0)) begin
                    repeat (2) @(negedge clk);
                    rx_valid = 1'b1;
                    rx_pid   = (p == PID_DATA0) ? resp_wr_pid : resp_rd_pid;
                    rx_data  = resp_data;
                    @(negedge clk);
                    rx_valid = 1'b0;
                end
            end
        end
    end

    task automatic wait_gnt(input int budget, output logic [1:0] g, output int t);
        g = 2'b00;
        t = 0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (wr_gnt || rd_gnt) begin
                g = {wr_gnt, rd_gnt};
                t = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget, output logic found, output logic [3:0] flags,
                             output logic [63:0] rdd, output int t);
        found = 1'b0; flags = 4'd0; rdd = 64'd0; t = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_done || rd_done) begin
                found = 1'b1;
                flags = {wr_done, wr_err, rd_done, rd_err};
                rdd   = rd_data;
                t     = cyc;
                return;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base_tok, base_d0, base_ack, t0, t1, diff;
        logic [1:0]  g;
        logic        found;
        logic [3:0]  flags;
        logic [63:0] rdd;
        resp_wr_pid = v.is_rd ? 4'd0 : v.resp;
        resp_rd_pid = v.is_rd ? v.resp : 4'd0;
        resp_data   = v.rx_data;
        base_tok = tok_cnt[v.is_rd ? PID_IN : PID_OUT];
        base_d0  = tok_cnt[PID_DATA0];
        base_ack = tok_cnt[PID_ACK];
        @(negedge clk);
        if (v.is_rd) begin
            rd_req = 1'b1; rd_addr = v.addr; rd_endp = v.endp;
        end else begin
            wr_req = 1'b1; wr_addr = v.addr; wr_endp = v.endp; wr_data = v.wdata;
        end
        wait_gnt(50, g, t0);
        check({tag, " gnt"}, 64'(g), v.is_rd ? 64'd1 : 64'd2);
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        wait_done(2000, found, flags, rdd, t1);
        check({tag, " done seen"}, 64'(found), 64'd1);
        check({tag, " done flags"}, 64'(flags),
              64'({~v.is_rd, ~v.is_rd & v.exp_err, v.is_rd, v.is_rd & v.exp_err}));
        check({tag, " token count"}, 64'(tok_cnt[v.is_rd ? PID_IN : PID_OUT] - base_tok), 64'(v.exp_tok));
        check({tag, " token addr/endp"}, 64'({last_tok_addr, last_tok_endp}), 64'({v.addr, v.endp}));
        check({tag, " data0 count"}, 64'(tok_cnt[PID_DATA0] - base_d0), v.is_rd ? 64'd0 : 64'(v.exp_tok));
        check({tag, " ack count"}, 64'(tok_cnt[PID_ACK] - base_ack),
              (v.is_rd && !v.exp_err) ? 64'd1 : 64'd0);
        if (!v.is_rd) check({tag, " data0 payload"}, last_d0_data, v.wdata);
        if (v.is_rd && !v.exp_err) check({tag, " rd_data"}, rdd, v.rx_data);
        if (v.exp_cyc != 0) begin
            diff = t1 - t0;
            check({tag, " cycles to done"},
                  (diff >= v.exp_cyc - 2 && diff <= v.exp_cyc + 2) ? 64'(v.exp_cyc) : 64'(diff),
                  64'(v.exp_cyc));
        end
    endtask

    initial begin : main
        logic [1:0]  g;
        logic        found, quiet_bad;
        logic [3:0]  flags;
        logic [63:0] rdd;
        int          t, base;
        vec_t        fresh;

        vecs[0] = '{1'b0, 7'h12, 4'h3, 64'hDEADBEEF_00C0FFEE, PID_ACK, 64'd0, 1'b0, 1, 0};
        vecs[1] = '{1'b1, 7'h05, 4'h1, 64'd0, PID_DATA0, 64'h0123456789ABCDEF, 1'b0, 1, 0};
        vecs[2] = '{1'b0, 7'h33, 4'h7, 64'h5555AAAA_1234_5678, PID_NAK, 64'd0, 1'b1, 4, 0};
        vecs[3] = '{1'b1, 7'h0A, 4'h2, 64'd0, 4'd0, 64'd0, 1'b1, 4, 1049};
        vecs[4] = '{1'b0, 7'h7F, 4'hF, 64'hFFFFFFFF_FFFFFFFF, PID_ACK, 64'd0, 1'b0, 1, 0};
        vecs[5] = '{1'b1, 7'h00, 4'h0, 64'd0, PID_NAK, 64'd0, 1'b1, 4, 0};
        vecs[6] = '{1'b1, 7'h7F, 4'hF, 64'd0, PID_DATA0, 64'hFEDCBA98_76543210, 1'b0, 1, 0};

        rst_L = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = 7'd0; wr_endp = 4'd0; wr_data = 64'd0; rd_addr = 7'd0; rd_endp = 4'd0;
        resp_wr_pid = 4'd0; resp_rd_pid = 4'd0; resp_data = 64'd0;
        repeat (3) @(negedge clk);
        check("reset ctrl outs", 64'({pktready, busy, wr_done, wr_err, rd_done, rd_err, wr_gnt, rd_gnt}), 64'd0);
        check("reset pid/addr/endp", 64'({pid, addr, endp}), 64'd0);
        check("reset data", data, 64'd0);
        check("reset rd_data", rd_data, 64'd0);
        rst_L = 1'b1;

        // Both requesters held from reset: write first, then strict alternation.
        resp_wr_pid = PID_ACK; resp_rd_pid = PID_DATA0; resp_data = 64'hA5A5_0000_5A5A_FFFF;
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 7'h11; wr_endp = 4'h1; wr_data = 64'h1111_2222_3333_4444;
        rd_req = 1'b1; rd_addr = 7'h22; rd_endp = 4'h2;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(50, g, t);
            check($sformatf("contention gnt %0d", k), 64'(g), (k % 2 == 0) ? 64'd2 : 64'd1);
            if (k == 3) begin
                @(negedge clk);
                wr_req = 1'b0;
                rd_req = 1'b0;
            end
            wait_done(500, found, flags, rdd, t);
            check($sformatf("contention done %0d", k), 64'({found, flags}),
                  (k % 2 == 0) ? 64'b11000 : 64'b10010);
        end

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting for a write handshake: everything clears, no done.
        resp_wr_pid = 4'd0; resp_rd_pid = 4'd0;
        base = tok_cnt[PID_DATA0];
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 7'h21; wr_endp = 4'h4; wr_data = 64'h0BAD_F00D_0000_0001;
        wait_gnt(50, g, t);
        check("rst-mid gnt", 64'(g), 64'd2);
        @(negedge clk);
        wr_req = 1'b0;
        for (int i = 0; i < 200 && tok_cnt[PID_DATA0] == base; i++) @(negedge clk);
        repeat (12) @(negedge clk);
        check("rst-mid busy before reset", 64'(busy), 64'd1);
        rst_L = 1'b0;
        @(negedge clk);
        check("rst-mid ctrl outs", 64'({pktready, busy, wr_done, wr_err, rd_done, rd_err, wr_gnt, rd_gnt}), 64'd0);
        check("rst-mid pid/addr/endp", 64'({pid, addr, endp}), 64'd0);
        check("rst-mid data", data, 64'd0);
        check("rst-mid rd_data", rd_data, 64'd0);
        rst_L = 1'b1;
        quiet_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (wr_done || rd_done || busy || pktready) quiet_bad = 1'b1;
        end
        check("rst-mid quiet after reset", 64'(quiet_bad), 64'd0);
        fresh = '{1'b0, 7'h21, 4'h4, 64'h0BAD_F00D_0000_0002, PID_ACK, 64'd0, 1'b0, 1, 0};
        run_vec(fresh, "rst-mid fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
